// File: rtl/fetch_flow_ctrl_pkg.sv
// Shared types and constants for the fetch flow controller.
`ifndef PD_BUF_SIZE
`define PD_BUF_SIZE 4
`endif

package fetch_flow_ctrl_pkg;
   localparam int FFC_BUF_SIZE      = `PD_BUF_SIZE;
   localparam int FFC_FID_W         = 5;
   localparam int FETCH_BLOCK_HW    = 8;
   localparam int FETCH_BLOCK_SHIFT = $clog2(FETCH_BLOCK_HW);

   typedef logic [FFC_FID_W-1:0] FetchID_t;

   typedef enum logic {
      FFC_FLUSH = 1'b0,
      FFC_RUN   = 1'b1
   } ffc_state_t;

   // Start of the next fetch block; the carry out of bit 30 is dropped.
   function automatic logic [30:0] next_block_pc(input logic [30:0] pc);
      logic [30-FETCH_BLOCK_SHIFT:0] blk;
      blk = pc[30:FETCH_BLOCK_SHIFT] + (31-FETCH_BLOCK_SHIFT)'(1);
      return {blk, {FETCH_BLOCK_SHIFT{1'b0}}};
   endfunction
endpackage

// File: rtl/ffc_credit_ctr.sv
// Saturating up/down counter with synchronous load; inc and dec together cancel.
module ffc_credit_ctr #(
   parameter int             W       = 3,
   parameter logic [W-1:0]   MAX     = '1,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] count
);
   logic [W-1:0] count_reg, count_next;

   always_comb begin
      count_next = count_reg;
      if (load)
         count_next = load_val;
      else if (inc && !dec && count_reg != MAX)
         count_next = count_reg + W'(1);
      else if (dec && !inc && count_reg != '0)
         count_next = count_reg - W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst)
         count_reg <= RST_VAL;
      else
         count_reg <= count_next;
   end

   assign count = count_reg;
endmodule

// File: rtl/fetch_flow_ctrl.sv
// Fetch PC/ID sequencer: issues a bundle request only when a predecode slot is reserved for it.
module fetch_flow_ctrl
   import fetch_flow_ctrl_pkg::*;
#(
   parameter int          BUF_SIZE  = FFC_BUF_SIZE,
   parameter int          FETCH_LAT = 2,
   parameter int          FID_W     = FFC_FID_W,
   parameter logic [30:0] RESET_PC  = 31'h0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        IN_mispred,
   input  logic [30:0]                 IN_mispredPC,
   input  logic                        IN_bpRedir,
   input  logic [30:0]                 IN_bpTarget,
   input  logic                        IN_stall,
   input  logic                        IN_icReady,
   input  logic                        IN_pdDeq,
   input  logic                        IN_fidFree,
   output logic                        OUT_fetchValid,
   output logic [30:0]                 OUT_fetchPC,
   output logic [FID_W-1:0]            OUT_fetchID,
   output logic                        OUT_flush,
   output logic [$clog2(BUF_SIZE):0]   OUT_credits
);
   localparam int                CW         = $clog2(BUF_SIZE) + 1;
   localparam int                DW         = $clog2(FETCH_LAT + 1);
   localparam logic [CW-1:0]     CREDIT_MAX = CW'(BUF_SIZE);
   localparam logic [FID_W-1:0]  FID_MAX    = '1;
   localparam logic [DW-1:0]     DRAIN_INIT = DW'(FETCH_LAT);

   ffc_state_t        state_reg, state_next;
   logic [DW-1:0]     drain_reg, drain_next;
   logic [30:0]       pc_reg, pc_next;
   logic [FID_W-1:0]  fid_reg, fid_next;
   logic [CW-1:0]     credits;
   logic [FID_W-1:0]  outstanding;
   logic              run, issue, credit_inc;

   assign run   = (state_reg == FFC_RUN);
   assign issue = run && IN_icReady && !IN_stall && !IN_mispred &&
                  (credits != '0) && (outstanding != FID_MAX);
   // Dequeues during a flush refer to entries that are being discarded anyway.
   assign credit_inc = IN_pdDeq && run && !IN_mispred;

   ffc_credit_ctr #(.W(CW), .MAX(CREDIT_MAX), .RST_VAL(CREDIT_MAX)) u_credits (
      .clk      (clk),
      .rst      (rst),
      .load     (IN_mispred),
      .load_val (CREDIT_MAX),
      .inc      (credit_inc),
      .dec      (issue),
      .count    (credits)
   );

   ffc_credit_ctr #(.W(FID_W), .MAX(FID_MAX), .RST_VAL('0)) u_outstanding (
      .clk      (clk),
      .rst      (rst),
      .load     (1'b0),
      .load_val ('0),
      .inc      (issue),
      .dec      (IN_fidFree),
      .count    (outstanding)
   );

   always_comb begin
      state_next = state_reg;
      drain_next = drain_reg;
      pc_next    = pc_reg;
      fid_next   = fid_reg;
      if (IN_mispred) begin
         state_next = FFC_FLUSH;
         drain_next = DRAIN_INIT;
         pc_next    = IN_mispredPC;
      end else begin
         if (state_reg == FFC_FLUSH) begin
            if (drain_reg <= DW'(1)) begin
               state_next = FFC_RUN;
               drain_next = '0;
            end else begin
               drain_next = drain_reg - DW'(1);
            end
         end
         if (issue) begin
            fid_next = fid_reg + FID_W'(1);
            pc_next  = IN_bpRedir ? IN_bpTarget : next_block_pc(pc_reg);
         end else if (IN_bpRedir) begin
            pc_next = IN_bpTarget;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= FFC_FLUSH;
         drain_reg <= DRAIN_INIT;
         pc_reg    <= RESET_PC;
         fid_reg   <= '0;
      end else begin
         state_reg <= state_next;
         drain_reg <= drain_next;
         pc_reg    <= pc_next;
         fid_reg   <= fid_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(IN_fidFree && outstanding == '0));
         assert (!(credit_inc && !issue && credits == CREDIT_MAX));
      end
   end

   assign OUT_fetchValid = issue;
   assign OUT_fetchPC    = pc_reg;
   assign OUT_fetchID    = fid_reg;
   assign OUT_flush      = !run;
   assign OUT_credits    = credits;
endmodule

// File: tb/tb_fetch_flow_ctrl.sv
// Directed bench for fetch_flow_ctrl: BUF_SIZE=4, FETCH_LAT=2, FID_W=5.
module tb_fetch_flow_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        IN_mispred;
   logic [30:0] IN_mispredPC;
   logic        IN_bpRedir;
   logic [30:0] IN_bpTarget;
   logic        IN_stall;
   logic        IN_icReady;
   logic        IN_pdDeq;
   logic        IN_fidFree;
   logic        OUT_fetchValid;
   logic [30:0] OUT_fetchPC;
   logic [4:0]  OUT_fetchID;
   logic        OUT_flush;
   logic [2:0]  OUT_credits;

   int errors = 0;
   int checks = 0;

   fetch_flow_ctrl #(.BUF_SIZE(4), .FETCH_LAT(2), .FID_W(5), .RESET_PC(31'h0)) dut (
      .clk            (clk),
      .rst            (rst),
      .IN_mispred     (IN_mispred),
      .IN_mispredPC   (IN_mispredPC),
      .IN_bpRedir     (IN_bpRedir),
      .IN_bpTarget    (IN_bpTarget),
      .IN_stall       (IN_stall),
      .IN_icReady     (IN_icReady),
      .IN_pdDeq       (IN_pdDeq),
      .IN_fidFree     (IN_fidFree),
      .OUT_fetchValid (OUT_fetchValid),
      .OUT_fetchPC    (OUT_fetchPC),
      .OUT_fetchID    (OUT_fetchID),
      .OUT_flush      (OUT_flush),
      .OUT_credits    (OUT_credits)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_issue(input string tag, input logic [31:0] pc, input logic [31:0] id,
                               input logic [31:0] cr);
      chk({tag, ".valid"}, {31'd0, OUT_fetchValid}, 32'd1);
      chk({tag, ".pc"}, {1'b0, OUT_fetchPC}, pc);
      chk({tag, ".id"}, {27'd0, OUT_fetchID}, id);
      chk({tag, ".credits"}, {29'd0, OUT_credits}, cr);
      $display("issue  %-10s pc=0x%0h id=%0d credits=%0d", tag, OUT_fetchPC, OUT_fetchID, OUT_credits);
   endtask

   task automatic expect_idle(input string tag, input logic [31:0] cr);
      chk({tag, ".valid"}, {31'd0, OUT_fetchValid}, 32'd0);
      chk({tag, ".credits"}, {29'd0, OUT_credits}, cr);
      $display("idle   %-10s flush=%0d credits=%0d", tag, OUT_flush, OUT_credits);
   endtask

   initial begin
      rst = 1'b1; IN_mispred = 1'b0; IN_mispredPC = '0; IN_bpRedir = 1'b0; IN_bpTarget = '0;
      IN_stall = 1'b0; IN_icReady = 1'b0; IN_pdDeq = 1'b0; IN_fidFree = 1'b0;
      tick();
      tick();

      // Reset state and the two-cycle flush drain.
      rst = 1'b0; IN_icReady = 1'b1;
      #1;
      chk("rst.flush", {31'd0, OUT_flush}, 32'd1);
      chk("rst.pc", {1'b0, OUT_fetchPC}, 32'h0);
      chk("rst.id", {27'd0, OUT_fetchID}, 32'd0);
      expect_idle("rst", 4);
      tick();
      chk("drain.flush", {31'd0, OUT_flush}, 32'd1);
      expect_idle("drain", 4);
      tick();
      chk("run.flush", {31'd0, OUT_flush}, 32'd0);
      expect_issue("i0", 32'h0, 0, 4);
      tick();
      expect_issue("i1", 32'h8, 1, 3);
      tick();
      expect_issue("i2", 32'h10, 2, 2);
      tick();
      expect_issue("i3", 32'h18, 3, 1);
      tick();
      expect_idle("nocred", 0);

      // One dequeue buys exactly one issue.
      IN_pdDeq = 1'b1;
      #1;
      expect_idle("deq", 0);
      tick();
      IN_pdDeq = 1'b0;
      #1;
      expect_issue("i4", 32'h20, 4, 1);
      tick();
      expect_idle("nocred2", 0);

      // Redirect without issue, then redirect on an issue cycle with a same-cycle dequeue.
      IN_bpRedir = 1'b1; IN_bpTarget = 31'h13;
      #1;
      expect_idle("redir", 0);
      tick();
      IN_bpRedir = 1'b0; IN_pdDeq = 1'b1;
      #1;
      expect_idle("deq2", 0);
      tick();
      IN_pdDeq = 1'b1; IN_bpRedir = 1'b1; IN_bpTarget = 31'h100;
      #1;
      expect_issue("i5", 32'h13, 5, 1);
      tick();
      IN_pdDeq = 1'b0; IN_bpRedir = 1'b0;
      #1;
      expect_issue("i6", 32'h100, 6, 1);
      tick();
      IN_pdDeq = 1'b1;
      #1;
      expect_idle("deq3", 0);
      tick();
      IN_pdDeq = 1'b0;

      // Mispredict with one credit left: blocks the issue, flushes, refills credits.
      IN_mispred = 1'b1; IN_mispredPC = 31'h4000;
      #1;
      chk("mp.pcHeld", {1'b0, OUT_fetchPC}, 32'h108);
      expect_idle("mp", 1);
      tick();
      IN_mispred = 1'b0;
      #1;
      chk("mp.flush", {31'd0, OUT_flush}, 32'd1);
      chk("mp.pc", {1'b0, OUT_fetchPC}, 32'h4000);
      expect_idle("mpflush", 4);
      tick();
      chk("mp.flush2", {31'd0, OUT_flush}, 32'd1);
      expect_idle("mpflush2", 4);
      tick();
      expect_issue("i7", 32'h4000, 7, 4);
      tick();

      // Fill the outstanding-ID window while dequeues keep credits level.
      IN_pdDeq = 1'b1;
      for (int i = 0; i < 23; i++) begin
         #1;
         expect_issue("fill", 32'h4008 + 32'(8 * i), 32'(8 + i), 3);
         tick();
      end
      IN_pdDeq = 1'b0;
      #1;
      chk("full.id", {27'd0, OUT_fetchID}, 32'd31);
      expect_idle("idfull", 3);

      IN_fidFree = 1'b1;
      #1;
      expect_idle("free1", 3);
      tick();
      IN_fidFree = 1'b0;
      #1;
      expect_issue("i31", 32'h40c0, 31, 3);
      tick();
      expect_idle("idfull2", 2);
      IN_fidFree = 1'b1;
      #1;
      expect_idle("free2", 2);
      tick();
      #1;
      expect_issue("wrap", 32'h40c8, 0, 2);
      tick();
      IN_fidFree = 1'b0;
      #1;
      expect_issue("i1b", 32'h40d0, 1, 1);
      tick();
      expect_idle("nocred3", 0);

      // Mispredict overrides a same-cycle dequeue, redirect and issue.
      IN_fidFree = 1'b1; IN_pdDeq = 1'b1;
      #1;
      expect_idle("refill", 0);
      tick();
      IN_fidFree = 1'b0; IN_pdDeq = 1'b0;
      #1;
      expect_issue("i2b", 32'h40d8, 2, 1);
      IN_mispred = 1'b1; IN_mispredPC = 31'h200; IN_pdDeq = 1'b1;
      IN_bpRedir = 1'b1; IN_bpTarget = 31'h300;
      #1;
      expect_idle("mpall", 1);
      tick();
      IN_mispred = 1'b0; IN_pdDeq = 1'b0; IN_bpRedir = 1'b0;
      #1;
      chk("mpall.flush", {31'd0, OUT_flush}, 32'd1);
      chk("mpall.pc", {1'b0, OUT_fetchPC}, 32'h200);
      expect_idle("mpall2", 4);
      tick();
      tick();
      expect_issue("i2c", 32'h200, 2, 4);

      // Reset mid-operation.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("rst2.flush", {31'd0, OUT_flush}, 32'd1);
      chk("rst2.pc", {1'b0, OUT_fetchPC}, 32'h0);
      chk("rst2.id", {27'd0, OUT_fetchID}, 32'd0);
      expect_idle("rst2", 4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
